// File: rtl/hdmi_rx_frame_writer_if.sv
// Avalon-MM burst write port from the RX frame writer to the LPDDR2 controller.
interface hdmi_rx_frame_writer_if;
   logic        avl_waitrequest_n;
   logic [26:0] avl_address;
   logic        avl_burstbegin;
   logic        avl_write;
   logic [31:0] avl_writedata;
   logic [7:0]  avl_burstcount;

   modport master (
      input  avl_waitrequest_n,
      output avl_address,
      output avl_burstbegin,
      output avl_write,
      output avl_writedata,
      output avl_burstcount
   );

   modport slave (
      output avl_waitrequest_n,
      input  avl_address,
      input  avl_burstbegin,
      input  avl_write,
      input  avl_writedata,
      input  avl_burstcount
   );
endinterface

// File: rtl/hdmi_rx_frame_writer.sv
// Captures one frame of ADV7611 RX video into LPDDR2 using fixed-length Avalon bursts.
// Pixels are buffered in a small FIFO so that every burst, once started, streams without bubbles.
module hdmi_rx_frame_writer #(
   parameter int unsigned PIXELS_PER_FRAME = 2073600,
   parameter int unsigned BURST_LEN        = 8,
   parameter int unsigned FIFO_DEPTH       = 512,
   parameter logic [26:0] BASE_ADDR        = 27'h0,
   parameter bit          VS_ACTIVE_HIGH   = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          arm,
   input  logic                          local_init_done,
   input  logic                          rx_vs,
   input  logic                          rx_de,
   input  logic [23:0]                   rx_d,
   hdmi_rx_frame_writer_if.master        avl,
   output logic                          busy,
   output logic                          done,
   output logic                          overflow
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam int          CW       = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] BL_C   = CW'(BURST_LEN);
   localparam logic [7:0]  BL8      = 8'(BURST_LEN);
   localparam logic [21:0] LAST_PIX = 22'(PIXELS_PER_FRAME - 1);

   typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DRAIN, DONE} state_t;

   state_t        state_q, state_d;
   logic          vs_q, vsPrev_q, de_q;
   logic [23:0]   d_q;
   logic [21:0]   pixelCnt_q, pixelCnt_d;
   logic          done_q, done_d, overflow_q, overflow_d;
   logic          restartAddr;

   logic [23:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wrPtr_q, rdPtr_q;
   logic [CW-1:0] fifoCount_q;

   logic          write_q, write_d, begin_q, begin_d;
   logic [7:0]    bcnt_q, bcnt_d, beatsLeft_q, beatsLeft_d;
   logic [26:0]   wordAddr_q, wordAddr_d;

   logic          frameStart, fifoFull, push, pop;

   assign frameStart = VS_ACTIVE_HIGH ? (vs_q & ~vsPrev_q) : (~vs_q & vsPrev_q);
   assign fifoFull   = (fifoCount_q == FULL_C);
   assign push       = (state_q == CAPTURE) && de_q && !fifoFull;
   assign pop        = write_q && avl.avl_waitrequest_n;

   // Register the video pins once; the VS edge is taken from the registered copy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vs_q     <= 1'b0;
         vsPrev_q <= 1'b0;
         de_q     <= 1'b0;
         d_q      <= 24'h0;
      end else begin
         vs_q     <= rx_vs;
         vsPrev_q <= vs_q;
         de_q     <= rx_de;
         d_q      <= rx_d;
      end
   end

   // Capture FSM state, pixel counter and sticky status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pixelCnt_q <= 22'h0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pixelCnt_q <= pixelCnt_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
      end
   end

   // Frame sequencing: wait for arm, lock onto the frame-start edge, count pixels, then drain.
   always_comb begin
      state_d     = state_q;
      pixelCnt_d  = pixelCnt_q;
      done_d      = done_q;
      overflow_d  = overflow_q;
      restartAddr = 1'b0;
      case (state_q)
         IDLE: begin
            if (arm && local_init_done) begin
               state_d    = ARMED;
               done_d     = 1'b0;
               overflow_d = 1'b0;
            end
         end
         ARMED: begin
            if (!local_init_done) begin
               state_d = IDLE;
            end else if (frameStart) begin
               state_d     = CAPTURE;
               pixelCnt_d  = 22'h0;
               restartAddr = 1'b1;
            end
         end
         CAPTURE: begin
            if (de_q) begin
               pixelCnt_d = pixelCnt_q + 22'd1;
               if (fifoFull) begin
                  overflow_d = 1'b1;
               end
               if (pixelCnt_q == LAST_PIX) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if ((fifoCount_q == '0) && !write_q) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pixel FIFO storage; contents need no reset because the count guards every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wrPtr_q] <= d_q;
      end
   end

   // FIFO pointers and occupancy; a same-cycle push and pop leaves the count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         fifoCount_q <= '0;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + AW'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifoCount_q <= fifoCount_q + CW'(1);
            2'b01:   fifoCount_q <= fifoCount_q - CW'(1);
            default: fifoCount_q <= fifoCount_q;
         endcase
      end
   end

   // Burst engine registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_q     <= 1'b0;
         begin_q     <= 1'b0;
         bcnt_q      <= 8'h0;
         beatsLeft_q <= 8'h0;
         wordAddr_q  <= BASE_ADDR;
      end else begin
         write_q     <= write_d;
         begin_q     <= begin_d;
         bcnt_q      <= bcnt_d;
         beatsLeft_q <= beatsLeft_d;
         wordAddr_q  <= wordAddr_d;
      end
   end

   // Start a burst only when all its words are already buffered, so write never drops mid-burst.
   always_comb begin
      write_d     = write_q;
      begin_d     = begin_q;
      bcnt_d      = bcnt_q;
      beatsLeft_d = beatsLeft_q;
      wordAddr_d  = wordAddr_q;
      if (write_q) begin
         if (avl.avl_waitrequest_n) begin
            begin_d     = 1'b0;
            beatsLeft_d = beatsLeft_q - 8'd1;
            if (beatsLeft_q == 8'd1) begin
               write_d    = 1'b0;
               wordAddr_d = wordAddr_q + 27'(bcnt_q);
            end
         end
      end else if (restartAddr) begin
         wordAddr_d = BASE_ADDR;
      end else if (fifoCount_q >= BL_C) begin
         write_d     = 1'b1;
         begin_d     = 1'b1;
         bcnt_d      = BL8;
         beatsLeft_d = BL8;
      end else if ((state_q == DRAIN) && (fifoCount_q != '0)) begin
         write_d     = 1'b1;
         begin_d     = 1'b1;
         bcnt_d      = 8'(fifoCount_q);
         beatsLeft_d = 8'(fifoCount_q);
      end
   end

   assign avl.avl_write      = write_q;
   assign avl.avl_burstbegin = begin_q;
   assign avl.avl_burstcount = bcnt_q;
   assign avl.avl_address    = wordAddr_q;
   assign avl.avl_writedata  = write_q ? {8'h00, mem[rdPtr_q]} : 32'h0;

   assign busy     = (state_q == ARMED) || (state_q == CAPTURE) || (state_q == DRAIN);
   assign done     = done_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_hdmi_rx_frame_writer.sv
// Self-checking bench for hdmi_rx_frame_writer: a queue-based model of the expected word
// stream and burst framing is compared against the Avalon port on every cycle.
module tb_hdmi_rx_frame_writer;

   localparam int PIX   = 60;
   localparam int BL    = 8;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset, arm, local_init_done, rx_vs, rx_de;
   logic [23:0] rx_d;
   logic        busy, done, overflow;

   hdmi_rx_frame_writer_if avl();

   hdmi_rx_frame_writer #(
      .PIXELS_PER_FRAME(PIX),
      .BURST_LEN(BL),
      .FIFO_DEPTH(DEPTH),
      .BASE_ADDR(27'h0),
      .VS_ACTIVE_HIGH(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .arm(arm),
      .local_init_done(local_init_done),
      .rx_vs(rx_vs),
      .rx_de(rx_de),
      .rx_d(rx_d),
      .avl(avl),
      .busy(busy),
      .done(done),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          wrMode = 0;
   logic [23:0] expQ[$];
   int          wordsAcc = 0;
   int          burstsSeen = 0;
   int          beats = 0;
   bit          inBurst = 1'b0;
   bit          needGap = 1'b0;
   logic [26:0] expAddr = '0;
   logic [7:0]  expCnt = '0;
   logic [26:0] lastBurstAddr = '0;
   logic [7:0]  lastBurstCnt = '0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] pix(input int f, input int k);
      logic [7:0] kb;
      kb = 8'(k);
      return {8'(f), kb, kb ^ 8'h5A};
   endfunction

   // Controller-side ready: always ready, random, or fully stalled.
   always @(posedge clk) begin
      #1;
      case (wrMode)
         0:       avl.avl_waitrequest_n = 1'b1;
         1:       avl.avl_waitrequest_n = 1'($urandom_range(0, 1));
         default: avl.avl_waitrequest_n = 1'b0;
      endcase
   end

   // Compare the Avalon port against the expected word stream and burst framing.
   always @(negedge clk) begin
      if (reset) begin
         inBurst = 1'b0;
         needGap = 1'b0;
      end else if (avl.avl_write) begin
         if (!inBurst) begin
            checkOutput("idle_cycle_before_burst", needGap, 0);
            checkOutput("burst_has_expected_data", expQ.size() > 0, 1);
            inBurst = 1'b1;
            beats   = 0;
            expAddr = 27'(wordsAcc);
            expCnt  = (expQ.size() >= BL) ? 8'(BL) : 8'(expQ.size());
            burstsSeen++;
            lastBurstAddr = expAddr;
            lastBurstCnt  = expCnt;
         end
         checkOutput("avl_address", avl.avl_address, expAddr);
         checkOutput("avl_burstcount", avl.avl_burstcount, expCnt);
         checkOutput("avl_burstbegin", avl.avl_burstbegin, beats == 0);
         if (expQ.size() > 0) begin
            checkOutput("avl_writedata", avl.avl_writedata, {8'h00, expQ[0]});
         end
         if (avl.avl_waitrequest_n) begin
            if (expQ.size() > 0) begin
               void'(expQ.pop_front());
            end
            beats++;
            wordsAcc++;
            if (beats >= int'(expCnt)) begin
               inBurst = 1'b0;
               needGap = 1'b1;
            end
         end
      end else begin
         if (inBurst) begin
            checkOutput("avl_write_held_in_burst", avl.avl_write, 1);
         end
         inBurst = 1'b0;
         needGap = 1'b0;
      end
   end

   task automatic applyStimulus(input logic vs, input logic de, input logic [23:0] d);
      @(posedge clk);
      #1;
      rx_vs = vs;
      rx_de = de;
      rx_d  = d;
   endtask

   task automatic armCapture();
      wordsAcc   = 0;
      burstsSeen = 0;
      @(posedge clk);
      #1 arm = 1'b1;
      @(posedge clk);
      #1 arm = 1'b0;
   endtask

   // One frame: optional DE before the edge, VS rise, nPix pixels separated by gap blank cycles.
   task automatic driveFrame(input int f, input int nPix, input int gap, input int keep, input int preDe);
      for (int i = 0; i < preDe; i++) begin
         applyStimulus(1'b0, 1'b1, {8'hEE, 8'(i), 8'h11});
      end
      applyStimulus(1'b0, 1'b0, 24'h0);
      for (int k = 0; k < keep; k++) begin
         expQ.push_back(pix(f, k));
      end
      applyStimulus(1'b1, 1'b0, 24'h0);
      applyStimulus(1'b1, 1'b0, 24'h0);
      for (int k = 0; k < nPix; k++) begin
         applyStimulus(1'b1, 1'b1, pix(f, k));
         for (int g = 0; g < gap; g++) begin
            applyStimulus(1'b1, 1'b0, 24'h0);
         end
      end
      applyStimulus(1'b0, 1'b0, 24'h0);
   endtask

   task automatic waitDone(input logic expOv, input int expWords, input int expBursts,
                           input logic [26:0] expLastAddr, input logic [7:0] expLastCnt);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("done_within_budget", done, 1);
      @(negedge clk);
      checkOutput("busy_after_done", busy, 0);
      checkOutput("overflow_flag", overflow, expOv);
      checkOutput("words_written", wordsAcc, expWords);
      checkOutput("burst_total", burstsSeen, expBursts);
      checkOutput("last_burst_addr", lastBurstAddr, expLastAddr);
      checkOutput("last_burst_count", lastBurstCnt, expLastCnt);
      checkOutput("words_left_unwritten", expQ.size(), 0);
   endtask

   // Bounded run: a hung DUT still ends the simulation with a reported failure.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int n;
      reset = 1'b1; arm = 1'b0; local_init_done = 1'b0;
      rx_vs = 1'b0; rx_de = 1'b0; rx_d = 24'h0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_avl_write", avl.avl_write, 0);
      checkOutput("reset_avl_address", avl.avl_address, 0);
      checkOutput("reset_avl_burstbegin", avl.avl_burstbegin, 0);
      checkOutput("reset_avl_burstcount", avl.avl_burstcount, 0);
      checkOutput("reset_avl_writedata", avl.avl_writedata, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_overflow", overflow, 0);
      reset = 1'b0;

      $display("[TB] arm without local_init_done");
      arm = 1'b1;
      driveFrame(9, 10, 0, 0, 0);
      arm = 1'b0;
      repeat (4) applyStimulus(1'b0, 1'b0, 24'h0);
      checkOutput("noinit_busy", busy, 0);
      checkOutput("noinit_done", done, 0);
      checkOutput("noinit_avl_write", avl.avl_write, 0);

      local_init_done = 1'b1;
      $display("[TB] nominal frame with pre-edge DE");
      wrMode = 0;
      armCapture();
      checkOutput("armed_busy", busy, 1);
      driveFrame(1, PIX, 1, PIX, 3);
      waitDone(1'b0, 60, 8, 27'd56, 8'd4);

      $display("[TB] random waitrequest frame");
      wrMode = 1;
      armCapture();
      checkOutput("arm_clears_done", done, 0);
      driveFrame(2, PIX, 4, PIX, 0);
      waitDone(1'b0, 60, 8, 27'd56, 8'd4);
      wrMode = 0;

      $display("[TB] local_init_done drop while armed");
      armCapture();
      checkOutput("initdrop_busy_armed", busy, 1);
      local_init_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("initdrop_busy_idle", busy, 0);
      local_init_done = 1'b1;

      $display("[TB] reset during a stalled burst");
      wrMode = 2;
      armCapture();
      driveFrame(5, 12, 0, 12, 0);
      n = 0;
      while (avl.avl_write !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checkOutput("write_before_reset", avl.avl_write, 1);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      checkOutput("reset_abort_write", avl.avl_write, 0);
      checkOutput("reset_abort_busy", busy, 0);
      expQ.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      wrMode = 0;
      armCapture();
      driveFrame(6, PIX, 2, PIX, 0);
      waitDone(1'b0, 60, 8, 27'd56, 8'd4);

      $display("[TB] overflow frame with stalled controller");
      wrMode = 2;
      armCapture();
      driveFrame(3, PIX, 0, DEPTH, 0);
      repeat (5) applyStimulus(1'b0, 1'b0, 24'h0);
      wrMode = 0;
      waitDone(1'b1, 16, 2, 27'd8, 8'd8);

      $display("[TB] re-arm clears overflow");
      armCapture();
      checkOutput("rearm_clears_overflow", overflow, 0);
      driveFrame(7, PIX, 1, PIX, 0);
      waitDone(1'b0, 60, 8, 27'd56, 8'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
